// File: rtl/reg_wb_arbiter.sv
// Write-port controller for the register bank: zero-clears x1..x31 after reset, then
// round-robin arbitrates ALU and load writebacks and tracks pending writes for decode.
module reg_wb_arbiter #(
    parameter int unsigned WIDTH_ADDR_LENGTH = 5,
    parameter int unsigned WIDTH_DATA_LENGTH = 32,
    parameter int unsigned NUM_REG_BANK      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         AluValid,
    input  logic [WIDTH_ADDR_LENGTH-1:0] AluAddr,
    input  logic [WIDTH_DATA_LENGTH-1:0] AluData,
    output logic                         AluReady,
    input  logic                         MemValid,
    input  logic [WIDTH_ADDR_LENGTH-1:0] MemAddr,
    input  logic [WIDTH_DATA_LENGTH-1:0] MemData,
    output logic                         MemReady,
    input  logic                         IssueValid,
    input  logic [WIDTH_ADDR_LENGTH-1:0] IssueAddr,
    output logic                         IssueReady,
    input  logic [WIDTH_ADDR_LENGTH-1:0] RsA,
    input  logic [WIDTH_ADDR_LENGTH-1:0] RsB,
    output logic                         BusyA,
    output logic                         BusyB,
    output logic                         RegWEn,
    output logic [WIDTH_ADDR_LENGTH-1:0] AddrD,
    output logic [WIDTH_DATA_LENGTH-1:0] DataD,
    output logic                         InitDone
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [WIDTH_ADDR_LENGTH-1:0] LastReg = WIDTH_ADDR_LENGTH'(NUM_REG_BANK - 1);

    state_e                         state_q, state_d;
    logic [WIDTH_ADDR_LENGTH-1:0]   cnt_q, cnt_d;
    logic                           last_mem_q, last_mem_d;
    logic [NUM_REG_BANK-1:0]        pending_q, pending_d;
    logic                           wen_q, wen_d;
    logic [WIDTH_ADDR_LENGTH-1:0]   addr_q, addr_d;
    logic [WIDTH_DATA_LENGTH-1:0]   data_q, data_d;
    logic                           done_q, done_d;

    logic                           in_run;
    logic                           grant_alu;
    logic                           grant_mem;
    logic                           xfer;
    logic [WIDTH_ADDR_LENGTH-1:0]   w_addr;
    logic [WIDTH_DATA_LENGTH-1:0]   w_data;

    assign in_run = (state_q == StRun);

    // On a tie the requester not named by the last-grant pointer wins.
    assign grant_alu = in_run && AluValid && (!MemValid || last_mem_q);
    assign grant_mem = in_run && MemValid && (!AluValid || !last_mem_q);
    assign xfer      = grant_alu || grant_mem;
    assign w_addr    = grant_mem ? MemAddr : AluAddr;
    assign w_data    = grant_mem ? MemData : AluData;

    assign AluReady   = grant_alu;
    assign MemReady   = grant_mem;
    assign IssueReady = in_run;
    assign BusyA      = pending_q[RsA];
    assign BusyB      = pending_q[RsB];
    assign RegWEn     = wen_q;
    assign AddrD      = addr_q;
    assign DataD      = data_q;
    assign InitDone   = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_mem_d = last_mem_q;
        pending_d  = pending_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = done_q;
        unique case (state_q)
            StInit: begin
                wen_d  = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + WIDTH_ADDR_LENGTH'(1);
                if (cnt_q == LastReg) begin
                    state_d = StRun;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                if (xfer) begin
                    wen_d      = (w_addr != '0);
                    addr_d     = w_addr;
                    data_d     = w_data;
                    last_mem_d = grant_mem;
                    pending_d[w_addr] = 1'b0;
                end
                // Applied after the clear so a same-edge issue keeps the bit for the newer writer.
                if (IssueValid && (IssueAddr != '0)) begin
                    pending_d[IssueAddr] = 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            cnt_q      <= WIDTH_ADDR_LENGTH'(1);
            last_mem_q <= 1'b1;
            pending_q  <= '0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_mem_q <= last_mem_d;
            pending_q  <= pending_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: init walk, a table of RUN-phase vectors, and
// hand-written reset sequences.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        AluValid, MemValid, IssueValid;
    logic [4:0]  AluAddr, MemAddr, IssueAddr, RsA, RsB;
    logic [31:0] AluData, MemData;
    logic        AluReady, MemReady, IssueReady, BusyA, BusyB, RegWEn, InitDone;
    logic [4:0]  AddrD;
    logic [31:0] DataD;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(
        .WIDTH_ADDR_LENGTH(5),
        .WIDTH_DATA_LENGTH(32),
        .NUM_REG_BANK     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .AluValid  (AluValid),
        .AluAddr   (AluAddr),
        .AluData   (AluData),
        .AluReady  (AluReady),
        .MemValid  (MemValid),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemReady  (MemReady),
        .IssueValid(IssueValid),
        .IssueAddr (IssueAddr),
        .IssueReady(IssueReady),
        .RsA       (RsA),
        .RsB       (RsB),
        .BusyA     (BusyA),
        .BusyB     (BusyB),
        .RegWEn    (RegWEn),
        .AddrD     (AddrD),
        .DataD     (DataD),
        .InitDone  (InitDone)
    );

    typedef struct packed {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  rsa;
        logic [4:0]  rsb;
        logic        e_ar;
        logic        e_mr;
        logic        e_ba;
        logic        e_bb;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        AluValid   = 1'b0; AluAddr = '0; AluData = '0;
        MemValid   = 1'b0; MemAddr = '0; MemData = '0;
        IssueValid = 1'b0; IssueAddr = '0;
        RsA = '0; RsB = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // av aa ad          mv ma md     iv ia rsa rsb  ar mr ba bb  wen addr data
        vecs[0]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 9, 0,  0, 0, 0, 0,  0, 31, 32'h0};
        vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 5, 0,  1, 0, 0, 0,  1, 5,  32'hDEADBEEF};
        vecs[2]  = '{0, 0, 32'h0,        1, 3, 32'h33, 0, 0, 0, 0,  0, 1, 0, 0,  1, 3,  32'h33};
        vecs[3]  = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1,  32'h11};
        vecs[4]  = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0, 0,  0, 1, 0, 0,  1, 2,  32'h22};
        vecs[5]  = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1,  32'h11};
        vecs[6]  = '{1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0, 0,  0, 1, 0, 0,  1, 2,  32'h22};
        vecs[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 7, 0,  0, 0, 0, 0,  0, 2,  32'h22};
        vecs[8]  = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 7, 0,  0, 0, 1, 0,  0, 2,  32'h22};
        vecs[9]  = '{0, 0, 32'h0,        1, 7, 32'h77, 0, 0, 7, 7,  0, 1, 1, 1,  1, 7,  32'h77};
        vecs[10] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 7, 0,  0, 0, 0, 0,  0, 7,  32'h77};
        vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 7, 7, 0,  0, 0, 0, 0,  0, 7,  32'h77};
        vecs[12] = '{0, 0, 32'h0,        1, 7, 32'h78, 1, 7, 7, 0,  0, 1, 1, 0,  1, 7,  32'h78};
        vecs[13] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 7, 0,  0, 0, 1, 0,  0, 7,  32'h78};
        vecs[14] = '{1, 7, 32'h79,       0, 0, 32'h0,  0, 0, 0, 7,  1, 0, 0, 1,  1, 7,  32'h79};
        vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 7,  0, 0, 0, 0,  0, 7,  32'h79};
        vecs[16] = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  1, 0, 0, 0,  1, 0, 0, 0,  0, 0,  32'hFFFFFFFF};
        vecs[17] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  32'hFFFFFFFF};
        vecs[18] = '{1, 10, 32'hA,       1, 11, 32'hB, 0, 0, 0, 0,  0, 1, 0, 0,  1, 11, 32'hB};
        vecs[19] = '{1, 10, 32'hA,       1, 11, 32'hB, 0, 0, 0, 0,  1, 0, 0, 0,  1, 10, 32'hA};

        // Reset held two cycles
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_wen", RegWEn, 0);
        chk("rst_addr", AddrD, 0);
        chk("rst_data", DataD, 0);
        chk("rst_done", InitDone, 0);
        chk("rst_issue_rdy", IssueReady, 0);

        // Init walk with requests pending: nothing may be accepted or scoreboarded
        rst = 1'b0;
        AluValid = 1'b1; AluAddr = 5'd4; AluData = 32'h44;
        MemValid = 1'b1; MemAddr = 5'd6;
        IssueValid = 1'b1; IssueAddr = 5'd9;
        for (int i = 1; i <= 31; i++) begin
            chk("init_alu_rdy", AluReady, 0);
            chk("init_mem_rdy", MemReady, 0);
            chk("init_issue_rdy", IssueReady, 0);
            tick();
            chk("init_wen", RegWEn, 1);
            chk("init_addr", AddrD, i);
            chk("init_data", DataD, 0);
            chk("init_done", InitDone, (i == 31));
        end
        idle();

        // RUN-phase vectors
        for (int v = 0; v < 20; v++) begin
            AluValid = vecs[v].av; AluAddr = vecs[v].aa; AluData = vecs[v].ad;
            MemValid = vecs[v].mv; MemAddr = vecs[v].ma; MemData = vecs[v].md;
            IssueValid = vecs[v].iv; IssueAddr = vecs[v].ia;
            RsA = vecs[v].rsa; RsB = vecs[v].rsb;
            #1;
            chk($sformatf("v%0d_alu_rdy", v), AluReady, vecs[v].e_ar);
            chk($sformatf("v%0d_mem_rdy", v), MemReady, vecs[v].e_mr);
            chk($sformatf("v%0d_issue_rdy", v), IssueReady, 1);
            chk($sformatf("v%0d_busy_a", v), BusyA, vecs[v].e_ba);
            chk($sformatf("v%0d_busy_b", v), BusyB, vecs[v].e_bb);
            tick();
            chk($sformatf("v%0d_wen", v), RegWEn, vecs[v].e_wen);
            chk($sformatf("v%0d_addr", v), AddrD, vecs[v].e_addr);
            chk($sformatf("v%0d_data", v), DataD, vecs[v].e_data);
            chk($sformatf("v%0d_done", v), InitDone, 1);
        end

        // Reset in RUN with a pending bit and a live request
        idle();
        IssueValid = 1'b1; IssueAddr = 5'd4;
        tick();
        idle();
        RsA = 5'd4;
        #1;
        chk("runrst_busy_pre", BusyA, 1);
        rst = 1'b1;
        AluValid = 1'b1; AluAddr = 5'd6; AluData = 32'h66;
        tick();
        chk("runrst_wen", RegWEn, 0);
        chk("runrst_addr", AddrD, 0);
        chk("runrst_data", DataD, 0);
        chk("runrst_done", InitDone, 0);
        chk("runrst_busy", BusyA, 0);
        chk("runrst_alu_rdy", AluReady, 0);

        // Walk to x12, then reset again mid-INIT
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("walk1_addr", AddrD, i);
        end
        rst = 1'b1;
        tick();
        chk("initrst_wen", RegWEn, 0);
        chk("initrst_addr", AddrD, 0);
        chk("initrst_done", InitDone, 0);
        rst = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("walk2_wen", RegWEn, 1);
            chk("walk2_addr", AddrD, i);
            chk("walk2_done", InitDone, (i == 31));
        end

        // The held ALU request is granted in the first RUN cycle
        chk("first_rdy", AluReady, 1);
        tick();
        AluValid = 1'b0;
        chk("first_wen", RegWEn, 1);
        chk("first_addr", AddrD, 6);
        chk("first_data", DataD, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port controller for the 32x32 register bank. After reset it sequences a zero-clear of registers x1..x31, because the bank has no reset of its own. It then shares the bank's single write port between the ALU and memory (load) writeback paths using round-robin arbitration. It also keeps a pending-write scoreboard so the decode stage can stall on operands whose writes have not yet landed.

## Interface
Parameters:
- WIDTH_ADDR_LENGTH, 5: register address width.
- WIDTH_DATA_LENGTH, 32: register data width.
- NUM_REG_BANK, 32: number of registers (1 << WIDTH_ADDR_LENGTH).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- AluValid  in  1  ALU writeback request.
- AluAddr  in  5  ALU destination register.
- AluData  in  32  ALU result.
- AluReady  out  1  ALU request accepted this cycle.
- MemValid  in  1  load writeback request.
- MemAddr  in  5  load destination register.
- MemData  in  32  load data.
- MemReady  out  1  load request accepted this cycle.
- IssueValid  in  1  decode issues an instruction that will write IssueAddr.
- IssueAddr  in  5  destination of the issued instruction.
- IssueReady  out  1  issue accepted (high only in RUN).
- RsA  in  5  decode source operand A.
- RsB  in  5  decode source operand B.
- BusyA  out  1  pending write to RsA.
- BusyB  out  1  pending write to RsB.
- RegWEn  out  1  bank write enable (registered).
- AddrD  out  5  bank write address (registered).
- DataD  out  32  bank write data (registered).
- InitDone  out  1  clear sequence finished (registered).

## Operation
- The FSM has two states, INIT and RUN.
- Reset forces INIT with walk counter = 1 and round-robin pointer last=MEM, so the ALU wins the first tie. It also clears the scoreboard and drives RegWEn=0, AddrD=0, DataD=0 and InitDone=0.
- INIT: every cycle, register RegWEn=1, AddrD=counter, DataD=0, then increment the counter.
  - When the strobe for AddrD=31 has been registered, go to RUN and set InitDone=1 on the same edge.
  - InitDone stays 1 until the next reset.
  - AluReady, MemReady and IssueReady are all 0 in INIT.
- RUN arbitration (combinational):
  - If exactly one of AluValid/MemValid is high, that requester is granted.
  - If both are high, the requester not named by the last-grant pointer is granted.
  - Ready is high only for the granted requester. A transfer is Valid&Ready.
  - The pointer updates to the granted requester on each transfer.
  - The loser must hold Valid, Addr and Data stable until granted.
- RUN write output:
  - On a transfer, register RegWEn=(Addr!=0), AddrD=Addr, DataD=Data.
  - With no transfer, register RegWEn=0; AddrD and DataD hold their values.
- Scoreboard:
  - NUM_REG_BANK pending bits; bit 0 is hardwired to 0.
  - Set: IssueValid&IssueReady with IssueAddr!=0 sets pending[IssueAddr].
  - Clear: a transfer with Addr!=0 clears pending[Addr] on the same edge the write is registered.
  - If set and clear target the same register on the same edge, the set wins and the bit stays 1 for the newer writer.
  - BusyA = pending[RsA] and BusyB = pending[RsB], read combinationally from the stored bits. A bit being set or cleared on the current edge is not yet reflected.
- Writes to x0 are accepted (Ready handshake completes) but never produce RegWEn=1.
- Reset asserted mid-operation, in INIT or RUN, aborts everything on that edge. The INIT walk then restarts at x1, and any in-flight request is dropped.

## Timing
- Clear sequence: 31 RegWEn strobes on the first 31 edges after rst deasserts.
  - InitDone is 1 from the 31st edge onward.
  - The first Ready can appear in the cycle after that edge.
- Writeback latency: transfer at edge N puts RegWEn/AddrD/DataD on the outputs after edge N; the bank captures them at edge N+1.
  - Decode must honour Busy until the pending bit clears at edge N.
- Throughput: one write per cycle. With both valids held high, grants alternate ALU, MEM, ALU, ...
- Ready depends combinationally on Valid; Valid must not depend on Ready.

## Test plan
- Reset then idle: rst high 2 cycles, then low → 31 consecutive strobes with AddrD=1..31 and DataD=0, InitDone=1 after the 31st. Bank reads x1..x31 = 0.
- Lone ALU request after init: AluAddr=5, AluData=0xDEADBEEF → AluReady=1 the same cycle; next cycle RegWEn=1, AddrD=5, DataD=0xDEADBEEF. Bank x5 = 0xDEADBEEF afterwards.
- Contention: both valids held 4 cycles (ALU x1=0x11, MEM x2=0x22, each re-presented after acceptance) → grant order ALU, MEM, ALU, MEM, with RegWEn=1 on every cycle.
- Scoreboard: issue x7, RsA=7 → BusyA=1 from the next cycle. A MEM transfer to x7 clears BusyA one cycle after the transfer. An issue to x7 on the same edge as the transfer keeps BusyA=1.
- x0 handling: ALU write to x0 with data 0xFFFFFFFF → AluReady=1, RegWEn stays 0, x0 reads 0. Issue to x0 with RsA=0 → BusyA=0.
- Mid-INIT reset: assert rst when AddrD=12 → next strobe after deassert is AddrD=1, InitDone=0 until 31 further strobes complete.
